// File: rtl/cnt_pkg.sv
// Shared definitions for the programmable counters and clock dividers.
package cnt_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cnt_state_e;

  // A modulo of 0 stands for 2^W: the wrap of m-1 leaves all-ones in the caller's low W bits.
  function automatic logic [CNT_MAX_W-1:0] mod_minus1(input logic [CNT_MAX_W-1:0] m);
    return m - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/mod_shadow_reg.sv
// Shadowed modulo register: writes park in a pending slot until the counter asks to apply them.
module mod_shadow_reg #(
  parameter int unsigned    W           = 8,
  parameter logic [W-1:0]   MOD_DEFAULT = W'(10)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mod_wr_i,
  input  logic [W-1:0] mod_in_i,
  input  logic         apply_i,
  output logic [W-1:0] ma_o,
  output logic [W-1:0] ma_next_o
);

  logic [W-1:0] ma_q, ma_d;
  logic [W-1:0] mp_q, mp_d;
  logic         pf_q, pf_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    mp_d = mod_wr_i ? mod_in_i : mp_q;
    pf_d = pf_q;
    ma_d = ma_q;
    if (apply_i) begin
      pf_d = 1'b0;
      // A write landing on the apply cycle goes straight into force.
      if (mod_wr_i)  ma_d = mod_in_i;
      else if (pf_q) ma_d = mp_q;
    end else if (mod_wr_i) begin
      pf_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments; the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ma_q <= MOD_DEFAULT;
      mp_q <= MOD_DEFAULT;
      pf_q <= 1'b0;
    end else begin
      ma_q <= ma_d;
      mp_q <= mp_d;
      pf_q <= pf_d;
    end
  end

  assign ma_o      = ma_q;
  assign ma_next_o = ma_d;

endmodule

// File: rtl/prog_cnt_mod.sv
// Runtime-programmable up/down modulo counter with load, clear and a one-shot run mode.
module prog_cnt_mod
  import cnt_pkg::*;
#(
  parameter int unsigned  W           = 8,
  parameter logic [W-1:0] MOD_DEFAULT = W'(10)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ce_i,
  input  logic         clr_i,
  input  logic         dir_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         mod_wr_i,
  input  logic [W-1:0] mod_in_i,
  input  logic         one_shot_i,
  input  logic         start_i,
  output logic [W-1:0] q_o,
  output logic         co_o,
  output logic         bo_o,
  output logic         busy_o,
  output logic         done_o
);

  cnt_state_e   state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         done_q, done_d;
  logic [W-1:0] ma, ma_next, ma_m1, ma_next_m1;
  logic         en, at_top, at_zero, tc, step, apply;

  mod_shadow_reg #(.W(W), .MOD_DEFAULT(MOD_DEFAULT)) u_mod_shadow (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mod_wr_i  (mod_wr_i),
    .mod_in_i  (mod_in_i),
    .apply_i   (apply),
    .ma_o      (ma),
    .ma_next_o (ma_next)
  );

  assign ma_m1      = W'(mod_minus1(CNT_MAX_W'(ma)));
  assign ma_next_m1 = W'(mod_minus1(CNT_MAX_W'(ma_next)));

  assign en      = ce_i && (!one_shot_i || state_q == ST_RUN);
  assign at_top  = (q_q == ma_m1);
  assign at_zero = (q_q == '0);
  assign tc      = dir_i ? at_top : at_zero;
  assign co_o    = en && dir_i && at_top;
  assign bo_o    = en && !dir_i && at_zero;

  // Clear and load outrank counting; all three are period boundaries for the modulo.
  assign step  = en && !clr_i && !load_i;
  assign apply = clr_i || load_i || (step && tc);

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = (load_val_i > ma_next_m1) ? ma_next_m1 : load_val_i;
    end else if (step) begin
      if (dir_i) q_d = tc ? '0 : q_q + W'(1);
      else       q_d = tc ? ma_next_m1 : q_q - W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clr_i || !one_shot_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (step && tc) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = done_q;

endmodule

// File: tb/tb_prog_cnt_mod.sv
// Directed bench for prog_cnt_mod: default W=8 instance plus a W=4 instance with modulo 2^W.
module tb_prog_cnt_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce, clr, dir, load, mod_wr, one_shot, start;
  logic [7:0] load_val, mod_in;
  logic [7:0] q;
  logic       co, bo, busy, done;

  logic       ce4, clr4;
  logic [3:0] q4;
  logic       co4, bo4, busy4, done4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_cnt_mod #(.W(8), .MOD_DEFAULT(8'd10)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .clr_i(clr), .dir_i(dir),
    .load_i(load), .load_val_i(load_val), .mod_wr_i(mod_wr), .mod_in_i(mod_in),
    .one_shot_i(one_shot), .start_i(start),
    .q_o(q), .co_o(co), .bo_o(bo), .busy_o(busy), .done_o(done)
  );

  prog_cnt_mod #(.W(4), .MOD_DEFAULT(4'd0)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce4), .clr_i(clr4), .dir_i(1'b1),
    .load_i(1'b0), .load_val_i(4'd0), .mod_wr_i(1'b0), .mod_in_i(4'd0),
    .one_shot_i(1'b0), .start_i(1'b0),
    .q_o(q4), .co_o(co4), .bo_o(bo4), .busy_o(busy4), .done_o(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_a [16];
    logic [7:0] exp_b [15];
    logic [7:0] exp_c [7];
    exp_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
              8'd8, 8'd9, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    exp_b = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
              8'd8, 8'd9, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    exp_c = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd4, 8'd3};

    rst_n = 1'b0; ce = 1'b1; clr = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;
    mod_wr = 1'b0; mod_in = '0; one_shot = 1'b0; start = 1'b0;
    ce4 = 1'b0; clr4 = 1'b0;
    tick; tick;
    check("rst_q", q, 0);
    check("rst_co", co, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q4", q4, 0);

    // Free-run up with the default modulo of 10
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      #1;
      check("free_q", q, i % 10);
      check("free_co", co, (i % 10) == 9);
      tick;
    end
    check("free_end_q", q, 5);

    // Shadow modulo written while Q = 3
    clr = 1'b1; tick; clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mod_wr = (i == 3); mod_in = 8'd4;
      #1;
      check("shadow_a_q", q, exp_a[i]);
      check("shadow_a_co", co, (i == 9) || (i == 13));
      tick;
    end
    mod_wr = 1'b0;

    // Restore modulo 10 through CLR, then write 4 on the terminal cycle
    clr = 1'b1; mod_wr = 1'b1; mod_in = 8'd10; tick; clr = 1'b0; mod_wr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mod_wr = (i == 9); mod_in = 8'd4;
      #1;
      check("shadow_b_q", q, exp_b[i]);
      check("shadow_b_co", co, (i == 9) || (i == 13));
      tick;
    end
    mod_wr = 1'b0;

    // Down count, modulo 5, load 7 clamps to 4
    dir = 1'b0; load = 1'b1; load_val = 8'd7; mod_wr = 1'b1; mod_in = 8'd5;
    tick;
    load = 1'b0; mod_wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("down_q", q, exp_c[i]);
      check("down_bo", bo, i == 4);
      check("down_co", co, 0);
      tick;
    end

    // One-shot, modulo 3, up
    clr = 1'b1; mod_wr = 1'b1; mod_in = 8'd3; one_shot = 1'b1; dir = 1'b1;
    tick;
    clr = 1'b0; mod_wr = 1'b0;
    #1;
    check("os_idle_q", q, 0);
    check("os_idle_busy", busy, 0);
    start = 1'b1;
    #1;
    check("os_start_co", co, 0);
    tick;
    start = 1'b0;
    #1;
    check("os_run0_busy", busy, 1);
    check("os_run0_q", q, 0);
    check("os_run0_done", done, 0);
    tick;
    start = 1'b1;
    #1;
    check("os_run1_q", q, 1);
    check("os_run1_busy", busy, 1);
    tick;
    start = 1'b0;
    #1;
    check("os_run2_q", q, 2);
    check("os_run2_co", co, 1);
    tick;
    #1;
    check("os_end_q", q, 0);
    check("os_end_busy", busy, 0);
    check("os_end_done", done, 1);
    check("os_end_co", co, 0);
    tick;
    #1;
    check("os_post_done", done, 0);
    check("os_post_busy", busy, 0);
    tick;
    #1;
    check("os_post_q", q, 0);
    check("os_post2_busy", busy, 0);

    // CLR and LOAD together in the middle of a run
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    check("prio_busy", busy, 1);
    tick;
    #1;
    check("prio_q1", q, 1);
    clr = 1'b1; load = 1'b1; load_val = 8'd2;
    tick;
    clr = 1'b0; load = 1'b0;
    #1;
    check("prio_clr_q", q, 0);
    check("prio_clr_busy", busy, 0);
    check("prio_clr_done", done, 0);
    tick;
    #1;
    check("prio_clr_done2", done, 0);

    // Reset with CE high drops a pending modulo and restores the default
    one_shot = 1'b0; ce = 1'b1; dir = 1'b1;
    tick;
    mod_wr = 1'b1; mod_in = 8'd2;
    #1;
    check("prerst_q", q, 1);
    tick;
    mod_wr = 1'b0; rst_n = 1'b0;
    tick;
    #1;
    check("rst2_q", q, 0);
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_co", co, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      #1;
      check("rst2_run_q", q, i % 10);
      tick;
    end

    // W = 4 with modulo 0 meaning 16
    ce = 1'b0; clr4 = 1'b1; tick; clr4 = 1'b0; ce4 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      check("w4_q", q4, i % 16);
      check("w4_co", co4, (i % 16) == 15);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
